spi_frame_slave: RTL
====================

# spi_frame_slave

Parametrised SPI slave frame engine for the stepper and I/O firmware. It generalises the fixed 4-axis, 20-byte SPI exchange to NCH channels of configurable width. Outgoing data (positions, digital inputs) is snapshotted coherently at frame start. Incoming data (velocities, config) is staged and committed atomically only when the frame is well-formed. It sits between the SPI pins and the stepgen, dout and watchdog logic of the top level.

## Interface
- NCH, 4: number of channels.
- TXW, 32: bits per channel sent on MISO. Multiple of 8.
- RXW, 16: bits per channel received on MOSI. Multiple of 8.
- DINW, 16: bits of din appended to MISO after the channels. Multiple of 8.
- CFGW, 16: bits of config received after the channel data. Multiple of 8.
- Derived byte counts: TXB=TXW/8, RXB=RXW/8, DINB=DINW/8, CFGB=CFGW/8.
- Derived frame length: FB=NCH*TXB+DINB.
- Legal only when NCH*RXB+CFGB <= FB.

Ports:
- clk  in  1  system clock. Single clock domain.
- nRESET  in  1  asynchronous active-low reset.
- SCK  in  1  SPI clock, mode 0. Asynchronous to clk.
- SSEL  in  1  active-low chip select. Asynchronous.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out, MSB first.
- tx_data  in  NCH*TXW  per-channel outgoing words. Channel 0 occupies the LSBs.
- din  in  DINW  digital inputs, sent after the channel words.
- rx_data  out  NCH*RXW  committed per-channel words. Channel 0 occupies the LSBs.
- cfg  out  CFGW  committed config word.
- commit  out  1  one-clk pulse when rx_data and cfg update.
- frame_err  out  1  one-clk pulse when a frame is rejected.
- busy  out  1  high while synchronised SSEL is active.

## Operation
- Synchronisation:
  - SCK and SSEL pass through 3-flop chains; edges are detected on stages [2:1].
  - MOSI is delayed 2 flops to stay aligned with SCK.
  - SCK high and low times must each be at least 3 clk.
- Frame start (synchronised SSEL falling edge):
  - tx_data and din are copied to a shadow register.
  - Byte counter and bit counter clear; the CRC accumulators clear.
  - MISO shift register loads MISO byte 0.
- Bit phase (mode 0):
  - On SCK rise: shift MOSI into rx_shift and increment bitcnt (3 bits).
  - On SCK fall: shift MISO left.
  - On the SCK fall that ends a byte (bitcnt==0 after 8 bits), increment bytecnt and load the next MISO byte.
- MISO byte order:
  - Channel 0 bytes first, each word little-endian, then channel 1, and so on.
  - Then din, little-endian.
  - Then the CRC byte if the CRC feature is compiled in.
  - Any byte beyond that is 0x00.
- MOSI byte order:
  - Bytes 0 .. NCH*RXB-1 go to staging rx, little-endian per channel.
  - The next CFGB bytes go to staging cfg.
  - Remaining bytes up to FB are ignored.
- Byte counter saturates at FB+1. It never wraps.
- Frame end (synchronised SSEL rising edge):
  - Commit when bitcnt==0 and bytecnt==FL, where FL=FB (FB+1 with the CRC feature). With the CRC feature, the CRC must also match.
  - Commit copies staging to rx_data and cfg, and pulses commit.
  - Otherwise pulse frame_err and leave rx_data and cfg unchanged.
- Rejection cases:
  - SSEL rises mid-byte (bitcnt!=0): frame_err.
  - Short frame or long frame: frame_err.
- Glitch handling: an SCK edge seen while SSEL is inactive is ignored.
- Reset:
  - Asserting nRESET mid-frame aborts the frame and clears all state.
  - After release, a frame already in progress is ignored until the next SSEL falling edge.

## Timing
- Reset values:
  - MISO=0, rx_data=0, cfg=0, commit=0, frame_err=0, busy=0.
  - All shadow, staging, counter and CRC registers are 0.
  - Synchroniser flops reset to 1 for SSEL and 0 for SCK.
- The snapshot is taken on the clk where the SSEL falling edge is detected. MISO bit 7 of byte 0 is valid 1 clk later, which is 3 clk after the SSEL pin falls.
- commit and frame_err rise 3 clk after the SSEL pin rises and last exactly 1 clk. rx_data and cfg take their new values on that same edge and hold until the next commit.
- Snapshot and commit are never simultaneous. If SSEL fall and rise are detected on consecutive clks, the end-of-frame evaluation completes first.
- Inter-frame SSEL high time must be at least 4 clk.

## Configuration
- SPI_FRAME_CRC_EN defined:
  - Frame length is FB+1.
  - MISO last byte is CRC-8 (poly 0x07, init 0x00, MSB-first) over all prior MISO bytes.
  - MOSI last byte must equal CRC-8 over all prior MOSI bytes; a mismatch gives frame_err.
- SPI_FRAME_CRC_EN undefined:
  - Frame length is FB.
  - No CRC logic is present and commit depends only on length and alignment.

## Test plan
Defaults apply (NCH=4, TXW=32, RXW=16, DINW=16, CFGW=16, so FB=18), no CRC unless stated.
- Nominal frame:
  - Stimulus: tx_data ch0=0x11223344, din=0xBEEF. MOSI bytes 0..3 = 34 12 78 56, bytes 8..9 = CD AB, other bytes 0x00.
  - Response: MISO bytes 0..3 = 44 33 22 11, bytes 16..17 = EF BE. One commit pulse. rx_data ch0=0x1234, ch1=0x5678, cfg=0xABCD.
- Coherent snapshot:
  - Stimulus: change tx_data ch0 to 0xFFFFFFFF after MISO byte 1.
  - Response: MISO bytes 0..3 still 44 33 22 11.
- Short frame:
  - Stimulus: SSEL rises after 17 bytes.
  - Response: frame_err pulse; rx_data and cfg keep their prior values.
- Misaligned and long frames:
  - Stimulus: SSEL rises after 18 bytes + 3 bits; separately, a 20-byte frame.
  - Response: frame_err in both cases; no commit. MISO bytes 18..19 = 0x00.
- Reset mid-frame:
  - Stimulus: nRESET low at byte 5, released while SSEL is still low, frame completes.
  - Response: all outputs 0; no commit until the next full frame.
- CRC_EN build:
  - Stimulus: 19-byte frame with a correct CRC byte, then the same frame with one data bit flipped.
  - Response: the first frame commits. The second gives frame_err and the outputs are unchanged.

Source files
------------

// File: rtl/spi_frame_slave_if.sv
// SPI pin and frame-data bundle for spi_frame_slave.
// The slave modport is the engine's view; master is the driving side.
interface spi_frame_slave_if #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned TXW  = 32,
    parameter int unsigned RXW  = 16,
    parameter int unsigned DINW = 16,
    parameter int unsigned CFGW = 16
);
    logic                SCK;
    logic                SSEL;
    logic                MOSI;
    logic                MISO;
    logic [NCH*TXW-1:0]  tx_data;
    logic [DINW-1:0]     din;
    logic [NCH*RXW-1:0]  rx_data;
    logic [CFGW-1:0]     cfg;
    logic                commit;
    logic                frame_err;
    logic                busy;

    modport slave (
        input  SCK, SSEL, MOSI, tx_data, din,
        output MISO, rx_data, cfg, commit, frame_err, busy
    );

    modport master (
        output SCK, SSEL, MOSI, tx_data, din,
        input  MISO, rx_data, cfg, commit, frame_err, busy
    );
endinterface

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave frame engine: coherent TX snapshot at frame start, atomic RX commit on good frames.
// Define SPI_FRAME_CRC_EN to append/check a CRC-8 (poly 0x07) trailer byte.
module spi_frame_slave #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned TXW  = 32,
    parameter int unsigned RXW  = 16,
    parameter int unsigned DINW = 16,
    parameter int unsigned CFGW = 16
) (
    input  logic             clk,
    input  logic             nRESET,
    spi_frame_slave_if.slave bus
);
    localparam int unsigned TXB  = TXW / 8;
    localparam int unsigned RXB  = RXW / 8;
    localparam int unsigned DINB = DINW / 8;
    localparam int unsigned CFGB = CFGW / 8;
    localparam int unsigned FB   = NCH * TXB + DINB;
    localparam int unsigned SB   = NCH * RXB + CFGB;
`ifdef SPI_FRAME_CRC_EN
    localparam int unsigned FL   = FB + 1;
`else
    localparam int unsigned FL   = FB;
`endif
    localparam int unsigned BCW  = $clog2(FB + 3);
    localparam int unsigned SHW  = FB * 8;
    localparam int unsigned SGW  = SB * 8;

    logic [2:0]          sck_s;
    logic [2:0]          ssel_s;
    logic [1:0]          mosi_d;
    logic [1:0]          settle;
    logic                in_frame;
    logic                byte_end;
    logic [2:0]          bitcnt;
    logic [BCW-1:0]      bytecnt;
    logic [BCW-1:0]      nxt_idx;
    logic [7:0]          tx_shift;
    logic [6:0]          rx_shift;
    logic [7:0]          rx_byte;
    logic [7:0]          tx_next;
    logic [SHW-1:0]      shadow;
    logic [SGW-1:0]      stage;
    logic [NCH*RXW-1:0]  rx_q;
    logic [CFGW-1:0]     cfg_q;
    logic                commit_q;
    logic                err_q;
    logic                sck_rise;
    logic                sck_fall;
    logic                ssel_fall;
    logic                ssel_rise;
    logic                frame_ok;

`ifdef SPI_FRAME_CRC_EN
    logic [7:0]          crc_tx;
    logic [7:0]          crc_rx;
    logic [7:0]          rx_last;
    logic [7:0]          tx_cur;
    logic [7:0]          crc_tx_nxt;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    assign crc_tx_nxt = crc8(crc_tx, tx_cur);
    assign frame_ok   = (bitcnt == 3'd0) && (bytecnt == BCW'(FL)) && (rx_last == crc_rx);
`else
    assign frame_ok   = (bitcnt == 3'd0) && (bytecnt == BCW'(FL));
`endif

    assign sck_rise  =  sck_s[1] & ~sck_s[2];
    assign sck_fall  = ~sck_s[1] &  sck_s[2];
    assign ssel_rise =  ssel_s[1] & ~ssel_s[2];
    // settle gates out the false fall produced when the chain refills after reset
    assign ssel_fall = ~ssel_s[1] &  ssel_s[2] & (settle == 2'd3);
    assign rx_byte   = {rx_shift, mosi_d[1]};
    assign nxt_idx   = bytecnt + BCW'(1);

    // Next outgoing byte: snapshot bytes, then optional CRC, then zero fill
    always_comb begin
        tx_next = 8'h00;
        if (nxt_idx < BCW'(FB))
            tx_next = 8'(shadow >> {nxt_idx, 3'b000});
`ifdef SPI_FRAME_CRC_EN
        else if (nxt_idx == BCW'(FB))
            tx_next = crc_tx_nxt;
`endif
    end

    // Pin synchronisers; MOSI delayed to line up with synchronised SCK
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            sck_s  <= 3'b000;
            ssel_s <= 3'b111;
            mosi_d <= 2'b00;
            settle <= 2'd0;
        end else begin
            sck_s  <= {sck_s[1:0], bus.SCK};
            ssel_s <= {ssel_s[1:0], bus.SSEL};
            mosi_d <= {mosi_d[0], bus.MOSI};
            if (settle != 2'd3)
                settle <= settle + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            in_frame <= 1'b0;
            byte_end <= 1'b0;
            bitcnt   <= 3'd0;
            bytecnt  <= '0;
            tx_shift <= 8'h00;
            rx_shift <= 7'h00;
            shadow   <= '0;
            stage    <= '0;
            rx_q     <= '0;
            cfg_q    <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef SPI_FRAME_CRC_EN
            crc_tx   <= 8'h00;
            crc_rx   <= 8'h00;
            rx_last  <= 8'h00;
            tx_cur   <= 8'h00;
`endif
        end else begin
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            // End-of-frame has priority so a back-to-back fall starts cleanly next clk
            if (in_frame && ssel_rise) begin
                in_frame <= 1'b0;
                if (frame_ok) begin
                    rx_q     <= stage[NCH*RXW-1:0];
                    cfg_q    <= stage[SGW-1 -: CFGW];
                    commit_q <= 1'b1;
                end else begin
                    err_q    <= 1'b1;
                end
            end else if (ssel_fall) begin
                in_frame <= 1'b1;
                shadow   <= {bus.din, bus.tx_data};
                tx_shift <= bus.tx_data[7:0];
                rx_shift <= 7'h00;
                bitcnt   <= 3'd0;
                bytecnt  <= '0;
                byte_end <= 1'b0;
`ifdef SPI_FRAME_CRC_EN
                crc_tx   <= 8'h00;
                crc_rx   <= 8'h00;
                rx_last  <= 8'h00;
                tx_cur   <= bus.tx_data[7:0];
`endif
            end else if (in_frame) begin
                if (sck_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bitcnt   <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        byte_end <= 1'b1;
                        for (int unsigned i = 0; i < SB; i++)
                            if (bytecnt == BCW'(i))
                                stage[i*8 +: 8] <= rx_byte;
`ifdef SPI_FRAME_CRC_EN
                        if (bytecnt < BCW'(FB))
                            crc_rx <= crc8(crc_rx, rx_byte);
                        else if (bytecnt == BCW'(FB))
                            rx_last <= rx_byte;
`endif
                    end
                end else if (sck_fall) begin
                    if (byte_end) begin
                        byte_end <= 1'b0;
                        tx_shift <= tx_next;
                        if (bytecnt != BCW'(FB + 1))
                            bytecnt <= nxt_idx;
`ifdef SPI_FRAME_CRC_EN
                        tx_cur   <= tx_next;
                        crc_tx   <= crc_tx_nxt;
`endif
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bus.MISO      = tx_shift[7];
    assign bus.rx_data   = rx_q;
    assign bus.cfg       = cfg_q;
    assign bus.commit    = commit_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = in_frame;

endmodule
